// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-side memory responder.
package mem_resp_pkg;

  localparam int WORD_W   = 32;
  localparam int ADDR_MSB = 63;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_t;

  // A word address is in range when no bit above the array index field is set.
  function automatic logic in_range(input logic [ADDR_MSB:2] addr, input int depth_log2);
    logic ok;
    ok = 1'b1;
    for (int i = 2; i <= ADDR_MSB; i++) begin
      if ((i > depth_log2 + 1) && addr[i]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Count-tracked circular FIFO; pointers wrap modulo DEPTH, count separates full from empty.
module resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  // A push at full is only taken when the head leaves in the same cycle.
  assign do_push_s  = push_i & (~full_o | pop_i);
  assign do_pop_s   = pop_i & ~empty_o;
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == CW'(0));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? PW'(0) : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? PW'(0) : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; empty slots are never presented downstream.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/resp_fifo_chk.sv
// Protocol checks on the response FIFO; overflow must be impossible by construction.
module resp_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   push_i,
  input logic                   pop_i,
  input logic                   full_i,
  input logic [$clog2(DEPTH):0] count_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_i && !pop_i))
    else $error("resp_fifo push while full");

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_i <= ($clog2(DEPTH) + 1)'(DEPTH))
    else $error("resp_fifo count above depth");

endmodule

// File: rtl/mem_resp_port.sv
// Data-side memory responder: posted writes, fixed-latency in-order reads, credit-gated intake.
module mem_resp_port
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wen,
  input  logic [ADDR_MSB:2]  req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WORD_W-1:0]  resp_rdata,
  output logic               resp_err
);

  localparam int NWORDS = 1 << DEPTH_LOG2;
  localparam int CW     = $clog2(QDEPTH) + 1;

  logic [WORD_W-1:0]     mem_q [NWORDS];
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  addr_ok_s, acc_s, rd_acc_s, wr_acc_s;
  resp_t                 rd0_s;
  logic [LATENCY-1:0]    pv_q;
  resp_t                 pd_q [LATENCY];
  logic                  push_s, pop_s, full_s, empty_s;
  resp_t                 head_s;
  logic [CW-1:0]         fifo_cnt_s;
  logic [CW-1:0]         cred_q, cred_d;
  logic                  ready_q, ready_d;

  assign addr_ok_s = in_range(req_addr, DEPTH_LOG2);
  assign idx_s     = req_addr[DEPTH_LOG2+1:2];
  assign acc_s     = req_valid & ready_q;
  assign rd_acc_s  = acc_s & ~req_wen;
  assign wr_acc_s  = acc_s & req_wen & addr_ok_s;

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[idx_s] <= req_wdata;
    end
  end

  always_comb begin
    rd0_s = '0;
    if (addr_ok_s) begin
      rd0_s.rdata = mem_q[idx_s];
      rd0_s.err   = 1'b0;
    end else begin
      rd0_s.rdata = '0;
      rd0_s.err   = 1'b1;
    end
  end

  // Latency pipeline: stage 0 captures the array at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= rd_acc_s;
      pd_q[0] <= rd0_s;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign push_s = pv_q[LATENCY-1];
  assign pop_s  = ~empty_s & resp_ready;

  resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (pd_q[LATENCY-1]),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .count_o     (fifo_cnt_s)
  );

  resp_fifo_chk #(
    .DEPTH (QDEPTH)
  ) u_fifo_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .full_i  (full_s),
    .count_i (fifo_cnt_s)
  );

  // Credits count reads in flight plus queued responses; ready is registered from the next count.
  always_comb begin
    cred_d = cred_q;
    case ({rd_acc_s, pop_s})
      2'b10:   cred_d = cred_q + CW'(1);
      2'b01:   cred_d = cred_q - CW'(1);
      default: cred_d = cred_q;
    endcase
    ready_d = (cred_d < CW'(QDEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred_q  <= CW'(0);
      ready_q <= 1'b0;
    end else begin
      cred_q  <= cred_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = ~empty_s;
  assign resp_rdata = resp_valid ? head_s.rdata : '0;
  assign resp_err   = resp_valid & head_s.err;

endmodule

// File: tb/tb_mem_resp_port.sv
// Randomised bench for mem_resp_port against a queue-based cycle model.
module tb_mem_resp_port;

  localparam int DL  = 10;
  localparam int LAT = 2;
  localparam int QD  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
  logic [63:2] req_addr = '0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  mem_resp_port #(.DEPTH_LOG2(DL), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  typedef struct { logic [31:0] d; logic e; int due; } exp_t;

  int          checks = 0, errors = 0, cyc = 0, outst = 0;
  logic [31:0] mem_m [1024];
  exp_t        exp_q[$];
  bit          ready_en = 1'b0, exp_valid = 1'b0, exp_ready = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;

  // Drive one cycle from a falling edge, advance the model across the rising edge.
  task automatic tick(input bit v, input bit w, input logic [63:2] a, input logic [31:0] wd, input bit rr);
    bit   acc, pop;
    exp_t e;
    req_valid = v; req_wen = w; req_addr = a; req_wdata = wd; resp_ready = rr;
    acc = v && exp_ready;
    pop = rr && exp_valid;
    @(posedge clk);
    cyc++;
    if (pop) begin exp_q.delete(0); outst--; end
    if (acc && w && (a < 62'd1024)) mem_m[int'(a[11:2])] = wd;
    if (acc && !w) begin
      e.d = (a < 62'd1024) ? mem_m[int'(a[11:2])] : 32'd0;
      e.e = !(a < 62'd1024);
      e.due = cyc + LAT;
      exp_q.push_back(e);
      outst++;
    end
    ready_en = 1'b1;
    @(negedge clk);
    exp_ready = ready_en && (outst < QD);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    if (exp_valid) begin exp_rdata = exp_q[0].d; exp_err = exp_q[0].e; end
  endtask

  task automatic model_reset();
    exp_q.delete(); outst = 0; ready_en = 1'b0; exp_ready = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int p = 0; p < 2; p++) begin
      if (p == 1) for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 62'(i), 32'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_low: got %b want 0", resp_valid); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", req_ready); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      checks++; if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'd0) begin errors++; $display("FAIL release_outputs: got %b%b%b %h want all 0", req_ready, resp_valid, resp_err, resp_rdata); end
      tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", req_ready); end
      for (int i = 0; i < 5; i++) begin
        tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stale_response: got %b want 0 (cycle %0d)", resp_valid, i); end
      end
    end
  endtask

  task automatic test_write_read();
    int k;
    tick(1'b1, 1'b1, 62'd5, 32'hDEADBEEF, 1'b1);
    tick(1'b1, 1'b0, 62'd5, 32'd0, 1'b1);
    k = 0;
    while (resp_valid !== 1'b1 && k < 10) begin tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1); k++; end
    checks++; if (k != LAT) begin errors++; $display("FAIL raw_latency: got %0d cycles want %0d", k, LAT); end
    checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_data: got %h want deadbeef", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL raw_err: got %b want 0", resp_err); end
    tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL raw_popped: got %b want 0", resp_valid); end
  endtask

  task automatic test_streaming();
    int nxt = 0, first_c = -1, last_c = -1;
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, 62'(i), 32'(i), 1'b1);
    for (int k = 0; k < 16 + LAT + 4; k++) begin
      if (k < 16) tick(1'b1, 1'b0, 62'(k), 32'd0, 1'b1);
      else        tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b want 1 (k %0d)", req_ready, k); end
      checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL stream_valid: got %b want %b (k %0d)", resp_valid, exp_valid, k); end
      if (resp_valid === 1'b1) begin
        checks++; if (resp_rdata !== 32'(nxt)) begin errors++; $display("FAIL stream_data: got %h want %h", resp_rdata, nxt); end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        nxt++;
      end
    end
    checks++; if (nxt != 16 || last_c - first_c != 15) begin errors++; $display("FAIL stream_count: got %0d resp over %0d cycles want 16 over 16", nxt, last_c - first_c + 1); end
  endtask

  task automatic test_backpressure();
    int nacc = 0, nxt = 0;
    bit was_ready, held = 1'b0;
    logic [31:0] hold_d = 32'd0;
    for (int k = 0; k < 8; k++) begin
      was_ready = req_ready;
      tick(1'b1, 1'b0, 62'(nacc), 32'd0, 1'b0);
      if (was_ready) nacc++;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready: got %b want %b (k %0d)", req_ready, exp_ready, k); end
      if (resp_valid === 1'b1) begin
        if (!held) begin held = 1'b1; hold_d = resp_rdata; end
        checks++; if (resp_rdata !== hold_d || resp_rdata !== 32'd0) begin errors++; $display("FAIL bp_head_stable: got %h want 00000000", resp_rdata); end
      end
    end
    checks++; if (nacc != QD) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", nacc, QD); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
    for (int k = 0; k < 10 && nxt < 4; k++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'(nxt)) begin errors++; $display("FAIL bp_drain: got %b/%h want 1/%h", resp_valid, resp_rdata, nxt); end
      tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1);
      nxt++;
    end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_recover: got ready %b valid %b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_out_of_range();
    logic [63:2] hi;
    logic [31:0] want_d [3];
    logic        want_e [3];
    int n = 0;
    hi = '0; hi[45] = 1'b1;
    want_d[0] = 32'h11111111; want_d[1] = 32'd0; want_d[2] = 32'd0;
    want_e[0] = 1'b0;         want_e[1] = 1'b1;  want_e[2] = 1'b1;
    tick(1'b1, 1'b1, 62'd0, 32'h11111111, 1'b1);
    tick(1'b1, 1'b1, 62'd1024, 32'hBAD0BAD0, 1'b1);
    tick(1'b1, 1'b0, 62'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 62'd1024, 32'd0, 1'b1);
    tick(1'b1, 1'b0, hi, 32'd0, 1'b1);
    for (int k = 0; k < 12 && n < 3; k++) begin
      if (resp_valid === 1'b1) begin
        checks++; if (resp_rdata !== want_d[n] || resp_err !== want_e[n]) begin errors++; $display("FAIL oor_resp%0d: got %h/%b want %h/%b", n, resp_rdata, resp_err, want_d[n], want_e[n]); end
        n++;
      end
      tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1);
    end
    checks++; if (n != 3) begin errors++; $display("FAIL oor_count: got %0d want 3", n); end
  endtask

  task automatic test_random();
    int nreads = 0, cnt = 0;
    bit v, w, rr, was_ready;
    logic [63:2] a;
    for (int i = 0; i < 32; i++) tick(1'b1, 1'b1, 62'(i), $urandom, 1'b1);
    while (nreads < 100 && cnt < 3000) begin
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 2) != 0);
      a  = ($urandom_range(0, 9) == 0) ? 62'(1024 + $urandom_range(0, 50)) : 62'($urandom_range(0, 31));
      was_ready = req_ready;
      tick(v, w, a, $urandom, rr);
      if (v && !w && was_ready) nreads++;
      cnt++;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready: got %b want %b (cycle %0d)", req_ready, exp_ready, cyc); end
      checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL rand_valid: got %b want %b (cycle %0d)", resp_valid, exp_valid, cyc); end
      if (exp_valid) begin
        checks++; if (resp_rdata !== exp_rdata || resp_err !== exp_err) begin errors++; $display("FAIL rand_data: got %h/%b want %h/%b (cycle %0d)", resp_rdata, resp_err, exp_rdata, exp_err, cyc); end
      end
    end
    checks++; if (nreads < 100) begin errors++; $display("FAIL rand_progress: got %0d reads want 100", nreads); end
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b0, 62'd0, 32'd0, 1'b1);
      if (exp_valid) begin
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== exp_err) begin errors++; $display("FAIL rand_drain: got %b %h/%b want 1 %h/%b", resp_valid, resp_rdata, resp_err, exp_rdata, exp_err); end
      end
    end
    checks++; if (resp_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL rand_empty: got valid %b pending %0d want 0 0", resp_valid, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timed out");
  end

endmodule
